// File: rtl/inst_rom_arbiter_if.sv
// inst_rom_arbiter_if: request/response channels of both ROM ports plus the ROM read port.
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              rready0;
    logic [DATA_W-1:0] rdata0;
    logic              flush0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic              rready1;
    logic [DATA_W-1:0] rdata1;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport slave (
        input  req0, addr0, rready0, flush0, req1, addr1, rready1, rom_inst,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_ce, rom_addr
    );

    modport master (
        output req0, addr0, rready0, flush0, req1, addr1, rready1, rom_inst,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_ce, rom_addr
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares one combinational ROM read port between fetch (port 0) and loads (port 1).
// Define ROM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module inst_rom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    inst_rom_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} slot_e;

    slot_e             st0_q, st0_d, st1_q, st1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              elig0, elig1, gnt0, gnt1;
`ifdef ROM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    always_comb begin
        // a full slot can take a new read only when its current response retires this cycle
        elig0 = rst && bus.req0 && !bus.flush0 && (st0_q == EMPTY || bus.rready0);
        elig1 = rst && bus.req1 && (st1_q == EMPTY || bus.rready1);
`ifdef ROM_ARB_RR_EN
        gnt1   = elig1 && (!elig0 || !last_q);
        gnt0   = elig0 && !gnt1;
        last_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
`else
        gnt1   = elig1 && !elig0;
        gnt0   = elig0;
`endif
        st0_d    = gnt0 ? FULL : (bus.flush0 || bus.rready0) ? EMPTY : st0_q;
        st1_d    = gnt1 ? FULL : bus.rready1 ? EMPTY : st1_q;
        rdata0_d = gnt0 ? bus.rom_inst : rdata0_q;
        rdata1_d = gnt1 ? bus.rom_inst : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st0_q    <= EMPTY;
            st1_q    <= EMPTY;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ROM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            st0_q    <= st0_d;
            st1_q    <= st1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ROM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rom_ce   = gnt0 || gnt1;
    assign bus.rom_addr = gnt0 ? bus.addr0 : gnt1 ? bus.addr1 : '0;
    assign bus.rvalid0  = st0_q == FULL;
    assign bus.rvalid1  = st1_q == FULL;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter: directed plan scenarios plus random traffic against a cycle reference model.
module tb_inst_rom_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a[31:2] == 30'd1) ? 32'h00500093 : ((a * 32'h9E3779B1) ^ 32'h13);
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_addr);

    // reference model: per-port response slot and the port granted most recently
    bit          m_v [2];
    logic [31:0] m_d [2];
    int          m_last = 1;
    int          win = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic [31:0] a0, input logic y0,
                         input logic f0, input logic q1, input logic [31:0] a1, input logic y1);
        bit ok0, ok1;
        rst = r;
        bus.req0 = q0; bus.addr0 = a0; bus.rready0 = y0; bus.flush0 = f0;
        bus.req1 = q1; bus.addr1 = a1; bus.rready1 = y1;
        #1;
        ok0 = r && q0 && !f0 && (!m_v[0] || y0);
        ok1 = r && q1 && (!m_v[1] || y1);
`ifdef ROM_ARB_RR_EN
        win = (ok0 && ok1) ? 1 - m_last : ok0 ? 0 : ok1 ? 1 : -1;
`else
        win = ok0 ? 0 : ok1 ? 1 : -1;
`endif
        check("gnt0", 32'(bus.gnt0), 32'(win == 0));
        check("gnt1", 32'(bus.gnt1), 32'(win == 1));
        check("rom_ce", 32'(bus.rom_ce), 32'(win >= 0));
        check("rom_addr", bus.rom_addr, win == 0 ? a0 : win == 1 ? a1 : 32'h0);
        check("rvalid0", 32'(bus.rvalid0), 32'(m_v[0]));
        check("rvalid1", 32'(bus.rvalid1), 32'(m_v[1]));
        check("rdata0", bus.rdata0, m_d[0]);
        check("rdata1", bus.rdata1, m_d[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_v[0] = 0; m_v[1] = 0; m_d[0] = '0; m_d[1] = '0; m_last = 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (win == p) begin
                    m_v[p] = 1;
                    m_d[p] = rom_word(p == 0 ? bus.addr0 : bus.addr1);
                    m_last = p;
                end else if ((p == 0 ? bus.rready0 : bus.rready1) || (p == 0 && bus.flush0)) begin
                    m_v[p] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic        q0, q1, y0, y1, f0, r;
        logic [31:0] a0, a1, hold1;
        // bring DUT out of its unknown power-up state before any checking
        drive(0, 1, 32'h0, 0, 0, 1, 32'h0, 0);
        n_tests = 0; n_fail = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_v[0] = 0; m_v[1] = 0; m_d[0] = '0; m_d[1] = '0; m_last = 1;

        // reset held with both requesting
        drive(0, 1, 32'h4, 1, 0, 1, 32'h8, 1); tick();

        // port 0 alone, back-to-back fetches
        drive(1, 1, 32'h4, 1, 0, 0, 32'h0, 1);
        check("p0_first_gnt", 32'(bus.gnt0), 32'h1);
        tick();
        drive(1, 1, 32'h8, 1, 0, 0, 32'h0, 1);
        check("p0_word1", bus.rdata0, 32'h00500093);
        tick();
        drive(1, 1, 32'hC, 1, 0, 0, 32'h0, 1); tick();
        drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 1);
        check("p0_third", bus.rvalid0 ? bus.rdata0 : 32'hX, rom_word(32'hC));
        tick();

        // fresh reset, then both ports request every cycle
        drive(0, 0, 32'h0, 1, 0, 0, 32'h0, 1); tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 32'h100 + 32'(i * 4), 1, 0, 1, 32'h200 + 32'(i * 4), 1);
`ifdef ROM_ARB_RR_EN
            check("tie_alt", 32'(bus.gnt0), 32'(i % 2 == 0));
`else
            check("tie_fixed", 32'(bus.gnt1), 32'h0);
`endif
            tick();
        end

        // backpressure on port 1
        drive(1, 0, 32'h0, 1, 0, 1, 32'h10, 1); tick();
        drive(1, 1, 32'h20, 1, 0, 1, 32'h14, 0);
        check("bp_no_gnt1", 32'(bus.gnt1), 32'h0);
        check("bp_gnt0", 32'(bus.gnt0), 32'h1);
        hold1 = bus.rdata1;
        tick();
        drive(1, 0, 32'h0, 1, 0, 1, 32'h14, 0);
        check("bp_stable", bus.rdata1, hold1);
        tick();
        drive(1, 0, 32'h0, 1, 0, 1, 32'h14, 1);
        check("bp_release", 32'(bus.gnt1), 32'h1);
        tick();

        // flush while port 0 is full
        drive(1, 1, 32'h30, 1, 0, 0, 32'h0, 1); tick();
        drive(1, 1, 32'h34, 0, 1, 1, 32'h40, 1);
        check("fl_no_gnt0", 32'(bus.gnt0), 32'h0);
        check("fl_gnt1", 32'(bus.gnt1), 32'h1);
        tick();
        drive(1, 0, 32'h0, 1, 0, 0, 32'h0, 1);
        check("fl_rvalid0", 32'(bus.rvalid0), 32'h0);
        tick();

        // reset mid-operation
        drive(1, 1, 32'h50, 0, 0, 1, 32'h54, 0); tick();
        drive(0, 1, 32'h50, 0, 0, 1, 32'h54, 0); tick();
        drive(1, 1, 32'h58, 1, 0, 1, 32'h5C, 1);
        check("rst_mid_rvalid0", 32'(bus.rvalid0), 32'h0);
        check("rst_tie_p0", 32'(bus.gnt0), 32'h1);
        tick();

        // random traffic; requesters hold request and address until granted
        q0 = 0; q1 = 0; a0 = '0; a1 = '0;
        for (int i = 0; i < 500; i++) begin
            r  = $urandom_range(99) >= 3;
            y0 = $urandom_range(3) != 0;
            y1 = $urandom_range(3) != 0;
            f0 = $urandom_range(9) == 0;
            if (!q0 || win == 0) begin
                q0 = $urandom_range(3) != 0;
                a0 = 32'($urandom_range(63)) << 2;
            end
            if (!q1 || win == 1) begin
                q1 = $urandom_range(2) != 0;
                a1 = 32'($urandom_range(63)) << 2;
            end
            drive(r, q0, a0, y0, f0, q1, a1, y1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
